// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single-request host port of an SDRAM controller between two
//   requesters, A (CPU data bus) and B (DMA / video fetch). One whole
//   transaction is granted at a time. The winner's request is registered
//   towards the controller, and read data plus a one-cycle ack go back to
//   the owner. No grant is issued until the controller reports that
//   initialisation is complete.
//
// Parameters
//   FIXED_PRIORITY : 0 = round-robin between A and B, 1 = A always wins a tie
//   ADDR_MSB       : MSB of the word address; addresses are [ADDR_MSB:1]
//
// Ports
//   clk, reset          : system clock, synchronous active-high reset
//   a_* / b_*           : requester ports (access, addr, wdata, wr_en,
//                         bytesel in; rdata, ack out)
//   m_config_done       : controller initialisation complete
//   m_access .. m_bytesel : registered request to the controller
//   m_rdata, m_compl    : controller read data and completion pulse
//   grant_b             : 1 while the current/last transaction belongs to B
module sdram_port_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int ADDR_MSB       = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_access,
  input  logic [ADDR_MSB:1]   a_addr,
  input  logic [15:0]         a_wdata,
  input  logic                a_wr_en,
  input  logic [1:0]          a_bytesel,
  output logic [15:0]         a_rdata,
  output logic                a_ack,
  input  logic                b_access,
  input  logic [ADDR_MSB:1]   b_addr,
  input  logic [15:0]         b_wdata,
  input  logic                b_wr_en,
  input  logic [1:0]          b_bytesel,
  output logic [15:0]         b_rdata,
  output logic                b_ack,
  input  logic                m_config_done,
  output logic                m_access,
  output logic [ADDR_MSB:1]   m_addr,
  output logic [15:0]         m_wdata,
  output logic                m_wr_en,
  output logic [1:0]          m_bytesel,
  input  logic [15:0]         m_rdata,
  input  logic                m_compl,
  output logic                grant_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_r;
  logic   last_b_r;   // 1 when B was the last port served
  logic   win_b_s;    // 1 when B wins the current arbitration

  // Arbitration: a lone requester always wins; on a tie use fixed or round-robin priority
  always_comb begin
    win_b_s = 1'b0;
    if (b_access && !a_access) begin
      win_b_s = 1'b1;
    end else if (b_access && a_access && (FIXED_PRIORITY == 1'b0) && !last_b_r) begin
      win_b_s = 1'b1;
    end else begin
      win_b_s = 1'b0;
    end
  end

  // Transaction FSM with all controller-side and requester-side outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      last_b_r  <= 1'b1;      // makes A win the first tie
      m_access  <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= 16'h0000;
      m_wr_en   <= 1'b0;
      m_bytesel <= 2'b00;
      grant_b   <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= 16'h0000;
      b_rdata   <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (m_config_done && (a_access || b_access)) begin
            m_addr    <= win_b_s ? b_addr    : a_addr;
            m_wdata   <= win_b_s ? b_wdata   : a_wdata;
            m_wr_en   <= win_b_s ? b_wr_en   : a_wr_en;
            m_bytesel <= win_b_s ? b_bytesel : a_bytesel;
            m_access  <= 1'b1;
            grant_b   <= win_b_s;
            last_b_r  <= win_b_s;
            state_r   <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // The request stays latched even if the owner drops access meanwhile
          if (m_compl) begin
            m_access <= 1'b0;
            if (grant_b) begin
              b_ack   <= 1'b1;
              b_rdata <= m_wr_en ? 16'h0000 : m_rdata;
            end else begin
              a_ack   <= 1'b1;
              a_rdata <= m_wr_en ? 16'h0000 : m_rdata;
            end
            state_r <= DRAIN;
          end else begin
            state_r <= BUSY;
          end
        end
        DRAIN: begin
          // One dead cycle so a lingering completion from the controller is not
          // mistaken for the next transaction
          a_ack   <= 1'b0;
          b_ack   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          m_access <= 1'b0;
          a_ack    <= 1'b0;
          b_ack    <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter. Two instances share all inputs:
// dut (round-robin) and dut_f (fixed priority, A wins ties); they stay in
// lockstep because a grant happens whenever any requester is active.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_access, b_access, a_wr_en, b_wr_en;
  logic [25:1] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic [1:0]  a_bytesel, b_bytesel;
  logic        m_config_done, m_compl;
  logic [15:0] m_rdata;

  logic [15:0] a_rdata, b_rdata, m_wdata;
  logic        a_ack, b_ack, m_access, m_wr_en, grant_b;
  logic [25:1] m_addr;
  logic [1:0]  m_bytesel;

  logic [15:0] f_a_rdata, f_b_rdata, f_m_wdata;
  logic        f_a_ack, f_b_ack, f_m_access, f_m_wr_en, f_grant_b;
  logic [25:1] f_m_addr;
  logic [1:0]  f_m_bytesel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.FIXED_PRIORITY(1'b0), .ADDR_MSB(25)) dut (
    .clk(clk), .reset(reset),
    .a_access(a_access), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
    .a_bytesel(a_bytesel), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_access(b_access), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
    .b_bytesel(b_bytesel), .b_rdata(b_rdata), .b_ack(b_ack),
    .m_config_done(m_config_done), .m_access(m_access), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .m_rdata(m_rdata), .m_compl(m_compl), .grant_b(grant_b)
  );

  sdram_port_arbiter #(.FIXED_PRIORITY(1'b1), .ADDR_MSB(25)) dut_f (
    .clk(clk), .reset(reset),
    .a_access(a_access), .a_addr(a_addr), .a_wdata(a_wdata), .a_wr_en(a_wr_en),
    .a_bytesel(a_bytesel), .a_rdata(f_a_rdata), .a_ack(f_a_ack),
    .b_access(b_access), .b_addr(b_addr), .b_wdata(b_wdata), .b_wr_en(b_wr_en),
    .b_bytesel(b_bytesel), .b_rdata(f_b_rdata), .b_ack(f_b_ack),
    .m_config_done(m_config_done), .m_access(f_m_access), .m_addr(f_m_addr),
    .m_wdata(f_m_wdata), .m_wr_en(f_m_wr_en), .m_bytesel(f_m_bytesel),
    .m_rdata(m_rdata), .m_compl(m_compl), .grant_b(f_grant_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int idle;
    int n;
    logic owner_b;

    reset = 1'b1; m_config_done = 1'b0; m_compl = 1'b0; m_rdata = 16'h0000;
    a_access = 1'b0; a_addr = 25'h0; a_wdata = 16'h0; a_wr_en = 1'b0; a_bytesel = 2'b00;
    b_access = 1'b0; b_addr = 25'h0; b_wdata = 16'h0; b_wr_en = 1'b0; b_bytesel = 2'b00;
    tick(); tick();
    // reset values
    check("rst_m_access", {31'd0, m_access}, 32'd0);
    check("rst_grant_b", {31'd0, grant_b}, 32'd0);
    check("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst_m_addr", {7'd0, m_addr}, 32'd0);
    check("rst_rdata", {a_rdata, b_rdata}, 32'd0);
    reset = 1'b0;

    // 1: no grant before configuration completes
    a_access = 1'b1; a_addr = 25'h0012345; a_wr_en = 1'b0; a_bytesel = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t1_hold_off", {30'd0, m_access, f_m_access}, 32'd0);
    end
    m_config_done = 1'b1;
    tick();
    check("t1_grant", {30'd0, m_access, f_m_access}, 32'd3);
    check("t1_m_addr", {7'd0, m_addr}, 32'h0012345);
    check("t1_grant_b", {31'd0, grant_b}, 32'd0);
    check("t1_wr_en", {31'd0, m_wr_en}, 32'd0);

    // 2: A read completes 6 cycles later with BEEF
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_busy", {31'd0, m_access}, 32'd1);
      check("t2_addr_stable", {7'd0, m_addr}, 32'h0012345);
    end
    m_compl = 1'b1; m_rdata = 16'hBEEF;
    tick();
    check("t2_a_ack", {31'd0, a_ack}, 32'd1);
    check("t2_a_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
    check("t2_b_ack", {31'd0, b_ack}, 32'd0);
    check("t2_m_access_drop", {31'd0, m_access}, 32'd0);
    m_compl = 1'b0; a_access = 1'b0;
    tick();
    check("t2_ack_one_cycle", {31'd0, a_ack}, 32'd0);
    check("t2_rdata_hold", {16'd0, a_rdata}, 32'h0000BEEF);

    // completion while idle is ignored
    m_compl = 1'b1;
    tick();
    check("idle_compl_acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("idle_compl_access", {31'd0, m_access}, 32'd0);
    m_compl = 1'b0;

    // 5: B write, stable request, zero rdata on write
    b_access = 1'b1; b_addr = 25'h00ABCDE; b_wdata = 16'h55AA; b_wr_en = 1'b1; b_bytesel = 2'b01;
    tick();
    check("t5_grant", {31'd0, m_access}, 32'd1);
    check("t5_grant_b", {31'd0, grant_b}, 32'd1);
    check("t5_m_addr", {7'd0, m_addr}, 32'h00ABCDE);
    b_wdata = 16'h0000; b_bytesel = 2'b10;   // must not leak into the latched request
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_wdata", {16'd0, m_wdata}, 32'h000055AA);
      check("t5_bytesel", {30'd0, m_bytesel}, 32'd1);
      check("t5_wr_en", {31'd0, m_wr_en}, 32'd1);
    end
    m_compl = 1'b1; m_rdata = 16'h1234;
    tick();
    check("t5_b_ack", {31'd0, b_ack}, 32'd1);
    check("t5_b_rdata_zero", {16'd0, b_rdata}, 32'd0);
    check("t5_a_ack", {31'd0, a_ack}, 32'd0);
    check("t5_a_rdata_hold", {16'd0, a_rdata}, 32'h0000BEEF);
    m_compl = 1'b0; b_access = 1'b0;
    tick();
    check("t5_b_ack_once", {31'd0, b_ack}, 32'd0);

    // 3 and 4: both held; round-robin A,B,A,B vs fixed A,A,A,A
    a_access = 1'b1; a_wr_en = 1'b0; a_addr = 25'h0012345;
    b_access = 1'b1; b_wr_en = 1'b0; b_addr = 25'h00ABCDE;
    idle = 0;
    for (int g = 0; g < 4; g++) begin
      owner_b = (g % 2 == 1);
      n = 0;
      do begin
        tick();
        n++;
        if (m_access === 1'b0) idle++;
      end while (m_access !== 1'b1 && n < 10);
      check("t3_grant_seen", {31'd0, m_access}, 32'd1);
      if (g > 0) check("t3_gap_ge2", {31'd0, (idle >= 2)}, 32'd1);
      check("t3_grant_b", {31'd0, grant_b}, {31'd0, owner_b});
      check("t3_m_addr", {7'd0, m_addr}, owner_b ? 32'h00ABCDE : 32'h0012345);
      check("t4_f_grant_b", {31'd0, f_grant_b}, 32'd0);
      check("t4_f_m_addr", {7'd0, f_m_addr}, 32'h0012345);
      tick(); tick();
      m_compl = 1'b1; m_rdata = 16'hC000 + 16'(g);
      tick();
      idle = 0;
      if (m_access === 1'b0) idle++;
      check("t3_acks", {30'd0, a_ack, b_ack}, owner_b ? 32'd1 : 32'd2);
      check("t3_rdata", {16'd0, owner_b ? b_rdata : a_rdata}, 32'h0000C000 + g);
      check("t4_f_acks", {30'd0, f_a_ack, f_b_ack}, 32'd2);
      m_compl = 1'b0;
      tick();
      if (m_access === 1'b0) idle++;
    end

    // 6: reset during BUSY; A served then reset, A must win the next tie
    tick();
    check("t6_pre_grant", {30'd0, m_access, grant_b}, 32'd2);
    tick();
    reset = 1'b1; m_compl = 1'b1; m_rdata = 16'hDEAD;
    tick();
    check("t6_m_access", {31'd0, m_access}, 32'd0);
    check("t6_no_ack", {28'd0, a_ack, b_ack, f_a_ack, f_b_ack}, 32'd0);
    check("t6_grant_b", {31'd0, grant_b}, 32'd0);
    check("t6_m_regs", {m_wdata, 13'd0, m_wr_en, m_bytesel}, 32'd0);
    check("t6_m_addr", {7'd0, m_addr}, 32'd0);
    check("t6_rdata", {a_rdata, b_rdata}, 32'd0);
    reset = 1'b0; m_compl = 1'b0;
    tick();
    check("t6_regrant", {31'd0, m_access}, 32'd1);
    check("t6_a_wins_tie", {31'd0, grant_b}, 32'd0);
    check("t6_m_addr_a", {7'd0, m_addr}, 32'h0012345);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
